// File: rtl/vend_pkg.sv
// Shared types and coin values for the vending sequencer.
// No logic here; only state encoding and coin denominations in cents.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_e;

    localparam int COIN_NICKEL  = 5;
    localparam int COIN_DIME    = 10;
    localparam int COIN_QUARTER = 25;
    localparam int RET_UNIT     = 5;

endpackage

// File: rtl/vend_if.sv
// Coin-slot / actuator bundle between the front end (master) and the sequencer (slave).
// Latency and backpressure are properties of the sequencer, not of this bundle.
interface vend_if #(
    parameter int CREDIT_W = 7
);
    logic                i_nickel;
    logic                i_dime;
    logic                i_quarter;
    logic                i_cancel;
    logic                i_ret_ready;
    logic                o_ret_valid;
    logic                o_dispense;
    logic                o_coin_reject;
    logic [CREDIT_W-1:0] o_credit;
    logic                o_busy;

    modport master (
        output i_nickel, i_dime, i_quarter, i_cancel, i_ret_ready,
        input  o_ret_valid, o_dispense, o_coin_reject, o_credit, o_busy
    );

    modport slave (
        input  i_nickel, i_dime, i_quarter, i_cancel, i_ret_ready,
        output o_ret_valid, o_dispense, o_coin_reject, o_credit, o_busy
    );
endinterface

// File: rtl/vend_coin_sel.sv
// Priority-encodes simultaneous coin pulses (nickel > dime > quarter) into one value.
// Latency: combinational. Backpressure: none; the caller decides whether to accept.
module vend_coin_sel
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 7
) (
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    output logic [CREDIT_W-1:0] coin_val,
    output logic                coin_vld,
    output logic                coin_multi
);

    always_comb begin
        coin_val = '0;
        if (nickel) begin
            coin_val = CREDIT_W'(COIN_NICKEL);
        end else if (dime) begin
            coin_val = CREDIT_W'(COIN_DIME);
        end else if (quarter) begin
            coin_val = CREDIT_W'(COIN_QUARTER);
        end
    end

    assign coin_vld   = nickel | dime | quarter;
    assign coin_multi = (nickel & dime) | (nickel & quarter) | (dime & quarter);

endmodule

// File: rtl/vend_sequencer.sv
// Vending sequencer: accumulates coin credit, strobes dispense, returns change as nickels.
// Latency: coin at N -> credit/dispense at N+1. Backpressure: o_ret_valid holds until i_ret_ready.
// Optional refund on i_cancel in COLLECT when VEND_CANCEL_EN is defined.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE    = 20,
    parameter int CREDIT_W = 7
) (
    input  logic   i_clk,
    input  logic   ni_rst,
    vend_if.slave  bus
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] RET_C   = CREDIT_W'(RET_UNIT);

    state_e              state;
    logic [CREDIT_W-1:0] credit;
    logic                dispense;
    logic                ret_valid;

    logic [CREDIT_W-1:0] coin_val;
    logic                coin_vld;
    logic                coin_multi;
    logic                cancel_hit;
    logic                coin_acc;
    logic                busy;
    logic [CREDIT_W-1:0] credit_next;

    vend_coin_sel #(
        .CREDIT_W (CREDIT_W)
    ) u_coin_sel (
        .nickel     (bus.i_nickel),
        .dime       (bus.i_dime),
        .quarter    (bus.i_quarter),
        .coin_val   (coin_val),
        .coin_vld   (coin_vld),
        .coin_multi (coin_multi)
    );

`ifdef VEND_CANCEL_EN
    assign cancel_hit = bus.i_cancel && (state == COLLECT);
`else
    logic unused_cancel;
    assign unused_cancel = bus.i_cancel;
    assign cancel_hit    = 1'b0;
`endif

    assign busy        = (state == DISPENSE) || (state == CHANGE);
    assign coin_acc    = coin_vld && !busy && !cancel_hit;
    assign credit_next = credit + coin_val;

    // A coin is rejected if it loses priority, arrives while busy, loses to cancel, or lands in reset.
    assign bus.o_coin_reject = coin_vld && (coin_multi || busy || cancel_hit || !ni_rst);

    always_ff @(posedge i_clk) begin
        if (!ni_rst) begin
            state     <= IDLE;
            credit    <= '0;
            dispense  <= 1'b0;
            ret_valid <= 1'b0;
        end else begin
            dispense <= 1'b0;
            case (state)
                IDLE, COLLECT: begin
                    if (cancel_hit) begin
                        state     <= CHANGE;
                        ret_valid <= 1'b1;
                    end else if (coin_acc) begin
                        credit <= credit_next;
                        if (credit_next >= PRICE_C) begin
                            state    <= DISPENSE;
                            dispense <= 1'b1;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                DISPENSE: begin
                    credit <= credit - PRICE_C;
                    if (credit != PRICE_C) begin
                        state     <= CHANGE;
                        ret_valid <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                CHANGE: begin
                    if (ret_valid && bus.i_ret_ready) begin
                        credit <= credit - RET_C;
                        if (credit == RET_C) begin
                            state     <= IDLE;
                            ret_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_credit    = credit;
    assign bus.o_dispense  = dispense;
    assign bus.o_ret_valid = ret_valid;
    assign bus.o_busy      = busy;

    a_credit_bound: assert property (@(posedge i_clk) disable iff (!ni_rst)
        credit <= CREDIT_W'(PRICE + 20));

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer at PRICE=20, CREDIT_W=7.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_vend_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    vend_if #(.CREDIT_W(7)) vif ();

    vend_sequencer #(
        .PRICE    (20),
        .CREDIT_W (7)
    ) dut (
        .i_clk  (clk),
        .ni_rst (rst_n),
        .bus    (vif.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_coins;
        vif.i_nickel  = 1'b0;
        vif.i_dime    = 1'b0;
        vif.i_quarter = 1'b0;
        vif.i_cancel  = 1'b0;
    endtask

    task automatic test_reset;
        clear_coins();
        vif.i_ret_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        total_cnt++; if (vif.o_credit !== 7'd0) $display("FAIL reset_credit got %0d want 0", vif.o_credit); else pass_cnt++;
        total_cnt++; if (vif.o_dispense !== 1'b0) $display("FAIL reset_dispense got %b want 0", vif.o_dispense); else pass_cnt++;
        total_cnt++; if (vif.o_ret_valid !== 1'b0) $display("FAIL reset_ret_valid got %b want 0", vif.o_ret_valid); else pass_cnt++;
        total_cnt++; if (vif.o_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", vif.o_busy); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_two_dimes;
        vif.i_ret_ready = 1'b0;
        vif.i_dime = 1'b1;
        #1;
        total_cnt++; if (vif.o_coin_reject !== 1'b0) $display("FAIL dime_reject got %b want 0", vif.o_coin_reject); else pass_cnt++;
        tick();
        vif.i_dime = 1'b0;
        total_cnt++; if (vif.o_credit !== 7'd10) $display("FAIL dime1_credit got %0d want 10", vif.o_credit); else pass_cnt++;
        total_cnt++; if (vif.o_dispense !== 1'b0) $display("FAIL dime1_dispense got %b want 0", vif.o_dispense); else pass_cnt++;
        tick();
        vif.i_dime = 1'b1;
        tick();
        vif.i_dime = 1'b0;
        total_cnt++; if (vif.o_credit !== 7'd20) $display("FAIL dime2_credit got %0d want 20", vif.o_credit); else pass_cnt++;
        total_cnt++; if (vif.o_dispense !== 1'b1) $display("FAIL dime2_dispense got %b want 1", vif.o_dispense); else pass_cnt++;
        total_cnt++; if (vif.o_busy !== 1'b1) $display("FAIL dime2_busy got %b want 1", vif.o_busy); else pass_cnt++;
        tick();
        total_cnt++; if (vif.o_dispense !== 1'b0) $display("FAIL dime_after_dispense got %b want 0", vif.o_dispense); else pass_cnt++;
        total_cnt++; if (vif.o_ret_valid !== 1'b0) $display("FAIL dime_ret_valid got %b want 0", vif.o_ret_valid); else pass_cnt++;
        total_cnt++; if (vif.o_busy !== 1'b0) $display("FAIL dime_idle_busy got %b want 0", vif.o_busy); else pass_cnt++;
        total_cnt++; if (vif.o_credit !== 7'd0) $display("FAIL dime_idle_credit got %0d want 0", vif.o_credit); else pass_cnt++;
    endtask

    task automatic test_quarter_change;
        vif.i_ret_ready = 1'b1;
        vif.i_quarter = 1'b1;
        tick();
        vif.i_quarter = 1'b0;
        total_cnt++; if (vif.o_credit !== 7'd25) $display("FAIL q_credit got %0d want 25", vif.o_credit); else pass_cnt++;
        total_cnt++; if (vif.o_dispense !== 1'b1) $display("FAIL q_dispense got %b want 1", vif.o_dispense); else pass_cnt++;
        tick();
        total_cnt++; if (vif.o_credit !== 7'd5) $display("FAIL q_change_credit got %0d want 5", vif.o_credit); else pass_cnt++;
        total_cnt++; if (vif.o_ret_valid !== 1'b1) $display("FAIL q_ret_valid got %b want 1", vif.o_ret_valid); else pass_cnt++;
        total_cnt++; if (vif.o_dispense !== 1'b0) $display("FAIL q_dispense_once got %b want 0", vif.o_dispense); else pass_cnt++;
        tick();
        total_cnt++; if (vif.o_credit !== 7'd0) $display("FAIL q_done_credit got %0d want 0", vif.o_credit); else pass_cnt++;
        total_cnt++; if (vif.o_ret_valid !== 1'b0) $display("FAIL q_done_ret_valid got %b want 0", vif.o_ret_valid); else pass_cnt++;
        total_cnt++; if (vif.o_busy !== 1'b0) $display("FAIL q_done_busy got %b want 0", vif.o_busy); else pass_cnt++;
        vif.i_ret_ready = 1'b0;
    endtask

    task automatic test_ready_toggle;
        logic ready_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int   exp_credit [5] = '{10, 10, 5, 5, 0};
        logic exp_valid [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int   hs = 0;
        vif.i_ret_ready = 1'b0;
        vif.i_dime = 1'b1;
        tick();
        vif.i_dime = 1'b0;
        vif.i_quarter = 1'b1;
        tick();
        vif.i_quarter = 1'b0;
        total_cnt++; if (vif.o_credit !== 7'd35) $display("FAIL tog_credit35 got %0d want 35", vif.o_credit); else pass_cnt++;
        total_cnt++; if (vif.o_dispense !== 1'b1) $display("FAIL tog_dispense got %b want 1", vif.o_dispense); else pass_cnt++;
        tick();
        total_cnt++; if (vif.o_credit !== 7'd15) $display("FAIL tog_credit15 got %0d want 15", vif.o_credit); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            vif.i_ret_ready = ready_pat[i];
            #1;
            if (vif.o_ret_valid && vif.i_ret_ready) hs++;
            tick();
            total_cnt++; if (vif.o_credit !== 7'(exp_credit[i])) $display("FAIL tog_credit_%0d got %0d want %0d", i, vif.o_credit, exp_credit[i]); else pass_cnt++;
            total_cnt++; if (vif.o_ret_valid !== exp_valid[i]) $display("FAIL tog_valid_%0d got %b want %b", i, vif.o_ret_valid, exp_valid[i]); else pass_cnt++;
        end
        vif.i_ret_ready = 1'b0;
        total_cnt++; if (hs !== 3) $display("FAIL tog_handshakes got %0d want 3", hs); else pass_cnt++;
    endtask

    task automatic test_multi_coin;
        vif.i_ret_ready = 1'b0;
        vif.i_nickel  = 1'b1;
        vif.i_quarter = 1'b1;
        #1;
        total_cnt++; if (vif.o_coin_reject !== 1'b1) $display("FAIL multi_reject got %b want 1", vif.o_coin_reject); else pass_cnt++;
        tick();
        clear_coins();
        total_cnt++; if (vif.o_credit !== 7'd5) $display("FAIL multi_credit got %0d want 5", vif.o_credit); else pass_cnt++;
        total_cnt++; if (vif.o_dispense !== 1'b0) $display("FAIL multi_dispense got %b want 0", vif.o_dispense); else pass_cnt++;
        vif.i_quarter = 1'b1;
        tick();
        vif.i_quarter = 1'b0;
        total_cnt++; if (vif.o_credit !== 7'd30) $display("FAIL multi_credit30 got %0d want 30", vif.o_credit); else pass_cnt++;
        tick();
        total_cnt++; if (vif.o_credit !== 7'd10) $display("FAIL multi_change got %0d want 10", vif.o_credit); else pass_cnt++;
        vif.i_dime = 1'b1;
        #1;
        total_cnt++; if (vif.o_coin_reject !== 1'b1) $display("FAIL busy_reject got %b want 1", vif.o_coin_reject); else pass_cnt++;
        tick();
        vif.i_dime = 1'b0;
        total_cnt++; if (vif.o_credit !== 7'd10) $display("FAIL busy_credit got %0d want 10", vif.o_credit); else pass_cnt++;
        total_cnt++; if (vif.o_ret_valid !== 1'b1) $display("FAIL busy_ret_hold got %b want 1", vif.o_ret_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid_change;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total_cnt++; if (vif.o_credit !== 7'd0) $display("FAIL rstmid_credit got %0d want 0", vif.o_credit); else pass_cnt++;
        total_cnt++; if (vif.o_ret_valid !== 1'b0) $display("FAIL rstmid_ret_valid got %b want 0", vif.o_ret_valid); else pass_cnt++;
        total_cnt++; if (vif.o_busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", vif.o_busy); else pass_cnt++;
        total_cnt++; if (vif.o_dispense !== 1'b0) $display("FAIL rstmid_dispense got %b want 0", vif.o_dispense); else pass_cnt++;
        tick();
    endtask

    task automatic test_cancel;
        vif.i_ret_ready = 1'b1;
        vif.i_nickel = 1'b1;
        tick();
        vif.i_nickel = 1'b0;
        vif.i_dime = 1'b1;
        tick();
        vif.i_dime = 1'b0;
        total_cnt++; if (vif.o_credit !== 7'd15) $display("FAIL cancel_credit15 got %0d want 15", vif.o_credit); else pass_cnt++;
`ifdef VEND_CANCEL_EN
        begin
            int   hs = 0;
            logic disp_seen = 1'b0;
            vif.i_cancel = 1'b1;
            vif.i_dime   = 1'b1;
            #1;
            total_cnt++; if (vif.o_coin_reject !== 1'b1) $display("FAIL cancel_coin_reject got %b want 1", vif.o_coin_reject); else pass_cnt++;
            tick();
            clear_coins();
            total_cnt++; if (vif.o_ret_valid !== 1'b1) $display("FAIL cancel_ret_valid got %b want 1", vif.o_ret_valid); else pass_cnt++;
            total_cnt++; if (vif.o_credit !== 7'd15) $display("FAIL cancel_hold_credit got %0d want 15", vif.o_credit); else pass_cnt++;
            for (int i = 0; i < 6; i++) begin
                if (vif.o_ret_valid && vif.i_ret_ready) hs++;
                if (vif.o_dispense) disp_seen = 1'b1;
                tick();
            end
            total_cnt++; if (hs !== 3) $display("FAIL cancel_handshakes got %0d want 3", hs); else pass_cnt++;
            total_cnt++; if (disp_seen !== 1'b0) $display("FAIL cancel_dispense got %b want 0", disp_seen); else pass_cnt++;
            total_cnt++; if (vif.o_credit !== 7'd0) $display("FAIL cancel_done_credit got %0d want 0", vif.o_credit); else pass_cnt++;
            total_cnt++; if (vif.o_busy !== 1'b0) $display("FAIL cancel_done_busy got %b want 0", vif.o_busy); else pass_cnt++;
        end
`else
        vif.i_cancel = 1'b1;
        #1;
        total_cnt++; if (vif.o_coin_reject !== 1'b0) $display("FAIL nocancel_reject got %b want 0", vif.o_coin_reject); else pass_cnt++;
        tick();
        vif.i_cancel = 1'b0;
        total_cnt++; if (vif.o_credit !== 7'd15) $display("FAIL nocancel_credit got %0d want 15", vif.o_credit); else pass_cnt++;
        total_cnt++; if (vif.o_ret_valid !== 1'b0) $display("FAIL nocancel_ret_valid got %b want 0", vif.o_ret_valid); else pass_cnt++;
        total_cnt++; if (vif.o_busy !== 1'b0) $display("FAIL nocancel_busy got %b want 0", vif.o_busy); else pass_cnt++;
        vif.i_nickel = 1'b1;
        tick();
        vif.i_nickel = 1'b0;
        total_cnt++; if (vif.o_dispense !== 1'b1) $display("FAIL nocancel_dispense got %b want 1", vif.o_dispense); else pass_cnt++;
        tick();
        total_cnt++; if (vif.o_credit !== 7'd0) $display("FAIL nocancel_done_credit got %0d want 0", vif.o_credit); else pass_cnt++;
`endif
        vif.i_ret_ready = 1'b0;
    endtask

    initial begin
        clear_coins();
        vif.i_ret_ready = 1'b0;
        test_reset();
        test_two_dimes();
        test_quarter_change();
        test_ready_toggle();
        test_multi_coin();
        test_reset_mid_change();
        test_cancel();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
